// File: rtl/sram_arbiter.sv
// Shares one SRAM-like memory port between the fetch (inst) and execute (data) requesters.
// Define ARB_RR_EN for round-robin arbitration; the default is fixed data-over-inst priority.
module sram_arbiter #(
    parameter int unsigned OST_DEPTH = 4,
    parameter int unsigned OST_AW    = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              inst_sram_req,
    input  logic [31:0]       inst_sram_addr,
    output logic              inst_sram_addr_ok,
    output logic              inst_sram_data_ok,
    output logic [31:0]       inst_sram_rdata,
    input  logic              data_sram_req,
    input  logic              data_sram_wr,
    input  logic [1:0]        data_sram_size,
    input  logic [3:0]        data_sram_wstrb,
    input  logic [31:0]       data_sram_addr,
    input  logic [31:0]       data_sram_wdata,
    output logic              data_sram_addr_ok,
    output logic              data_sram_data_ok,
    output logic [31:0]       data_sram_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [31:0]       mem_rdata,
    output logic [OST_AW:0]   ost_cnt
);

    localparam logic [OST_AW:0] FULL_CNT = (OST_AW + 1)'(OST_DEPTH);

    logic                 lock;
    logic                 lock_id;
    logic                 gnt;          // 0 = inst, 1 = data
    logic                 granted_req;
    logic                 full;
    logic                 accept;
    logic                 pop;
    logic                 head;
    logic [OST_DEPTH-1:0] id_fifo;
    logic [OST_AW-1:0]    wptr;
    logic [OST_AW-1:0]    rptr;
    logic [OST_AW:0]      cnt;
`ifdef ARB_RR_EN
    logic                 rr_last;
`endif

    always_comb begin
        gnt = data_sram_req;
        if (lock) begin
            gnt = lock_id;
        end else if (inst_sram_req && data_sram_req) begin
`ifdef ARB_RR_EN
            gnt = ~rr_last;
`else
            gnt = 1'b1;
`endif
        end
    end

    assign granted_req = gnt ? data_sram_req : inst_sram_req;
    assign full        = (cnt == FULL_CNT);
    assign mem_req     = granted_req & ~full;
    assign accept      = mem_req & mem_addr_ok;

    // Fields are zeroed while no request is presented so the port is quiet in reset and idle.
    assign mem_wr    = mem_req & gnt & data_sram_wr;
    assign mem_size  = !mem_req ? 2'd0 : (gnt ? data_sram_size : 2'd2);
    assign mem_wstrb = (mem_req && gnt) ? data_sram_wstrb : '0;
    assign mem_addr  = !mem_req ? '0 : (gnt ? data_sram_addr : inst_sram_addr);
    assign mem_wdata = (mem_req && gnt) ? data_sram_wdata : '0;

    assign inst_sram_addr_ok = accept & ~gnt;
    assign data_sram_addr_ok = accept & gnt;

    // A data_ok with nothing outstanding is spurious and is dropped.
    assign pop  = mem_data_ok & (cnt != '0);
    assign head = id_fifo[rptr];

    assign inst_sram_data_ok = pop & ~head;
    assign data_sram_data_ok = pop & head;
    assign inst_sram_rdata   = mem_rdata;
    assign data_sram_rdata   = mem_rdata;
    assign ost_cnt           = cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            lock    <= 1'b0;
            lock_id <= 1'b0;
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            id_fifo <= '0;
`ifdef ARB_RR_EN
            rr_last <= 1'b0;
`endif
        end else begin
            if (accept) begin
                id_fifo[wptr] <= gnt;
                wptr          <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (accept) begin
                lock <= 1'b0;
            end else if (mem_req) begin
                lock    <= 1'b1;
                lock_id <= gnt;
            end
`ifdef ARB_RR_EN
            if (accept) begin
                rr_last <= gnt;
            end
`endif
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: fixed vector table, directed corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_sram_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    logic [2:0]  ost_cnt;

    sram_arbiter #(.OST_DEPTH(DEPTH), .OST_AW(2)) dut (
        .clk(clk), .rstn(rstn),
        .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .ost_cnt(ost_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ir;
        logic [31:0] ia;
        bit          dr;
        bit          dw;
        logic [1:0]  ds;
        logic [3:0]  st;
        logic [31:0] da;
        logic [31:0] wd;
        bit          aok;
        bit          dok;
        logic [31:0] rd;
    } stim_t;

    typedef struct {
        bit ir, dr, dw, aok, dok;
        bit e_mreq, e_mwr, e_iaok, e_daok, e_idok, e_ddok;
        int e_cnt;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: outstanding IDs in order of acceptance, plus pending-grant memory.
    int q[$];
    bit lk, lk_id, rr;

    bit          seen_mreq, seen_mwr, seen_iaok, seen_daok, seen_idok, seen_ddok;
    logic [2:0]  seen_cnt;
    logic [31:0] seen_maddr, seen_irdata;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.ds = 2'd2;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        inst_sram_req   = s.ir;
        inst_sram_addr  = s.ia;
        data_sram_req   = s.dr;
        data_sram_wr    = s.dw;
        data_sram_size  = s.ds;
        data_sram_wstrb = s.st;
        data_sram_addr  = s.da;
        data_sram_wdata = s.wd;
        mem_addr_ok     = s.aok;
        mem_data_ok     = s.dok;
        mem_rdata       = s.rd;
    endtask

    task automatic do_reset();
        drive(idle());
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_size", mem_size, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_ost_cnt", ost_cnt, 0);
        chk("rst_addr_ok", {inst_sram_addr_ok, data_sram_addr_ok}, 0);
        chk("rst_data_ok", {inst_sram_data_ok, data_sram_data_ok}, 0);
        q.delete();
        lk = 0; lk_id = 0; rr = 0;
        rstn = 1'b1;
        @(negedge clk);
    endtask

    // One clock: drive at negedge, check before posedge, advance the model after it.
    task automatic cyc(input stim_t s);
        bit g, greq, emreq, acc, epop, head;
        logic [31:0] e_size, e_strb, e_addr, e_wdata;
        drive(s);
        #1;
        if (lk) g = lk_id;
        else if (s.ir && s.dr) begin
`ifdef ARB_RR_EN
            g = !rr;
`else
            g = 1'b1;
`endif
        end else g = s.dr;
        greq  = g ? s.dr : s.ir;
        emreq = greq && (q.size() < DEPTH);
        acc   = emreq && s.aok;
        epop  = s.dok && (q.size() > 0);
        head  = epop ? (q[0] == 1) : 1'b0;
        e_size  = !emreq ? 32'd0 : (g ? 32'(s.ds) : 32'd2);
        e_strb  = (emreq && g) ? 32'(s.st) : 32'd0;
        e_addr  = !emreq ? 32'd0 : (g ? s.da : s.ia);
        e_wdata = (emreq && g) ? s.wd : 32'd0;
        chk("mem_req", mem_req, emreq);
        chk("mem_wr", mem_wr, emreq && g && s.dw);
        chk("mem_size", mem_size, e_size);
        chk("mem_wstrb", mem_wstrb, e_strb);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("inst_addr_ok", inst_sram_addr_ok, acc && !g);
        chk("data_addr_ok", data_sram_addr_ok, acc && g);
        chk("inst_data_ok", inst_sram_data_ok, epop && !head);
        chk("data_data_ok", data_sram_data_ok, epop && head);
        chk("inst_rdata", inst_sram_rdata, s.rd);
        chk("data_rdata", data_sram_rdata, s.rd);
        chk("ost_cnt", ost_cnt, q.size());
        seen_mreq = mem_req; seen_mwr = mem_wr; seen_iaok = inst_sram_addr_ok;
        seen_daok = data_sram_addr_ok; seen_idok = inst_sram_data_ok;
        seen_ddok = data_sram_data_ok; seen_cnt = ost_cnt; seen_maddr = mem_addr;
        seen_irdata = inst_sram_rdata;
        @(posedge clk);
        if (epop) void'(q.pop_front());
        if (acc) begin
            q.push_back(int'(g));
            lk = 0;
            rr = g;
        end else if (emreq) begin
            lk = 1;
            lk_id = g;
        end
        @(negedge clk);
    endtask

    vec_t  tbl[10];
    stim_t s;
`ifdef ARB_RR_EN
    localparam bit RR_ON = 1'b1;
`else
    localparam bit RR_ON = 1'b0;
`endif

    initial begin
        tbl[0] = '{0,0,0,0,0, 0,0,0,0,0,0, 0};
        tbl[1] = '{1,0,0,1,0, 1,0,1,0,0,0, 0};
        tbl[2] = '{0,1,1,1,0, 1,1,0,1,0,0, 1};
        tbl[3] = '{0,0,0,0,1, 0,0,0,0,1,0, 2};
        tbl[4] = '{1,0,0,0,0, 1,0,0,0,0,0, 1};
        tbl[5] = '{1,1,0,1,0, 1,0,1,0,0,0, 1};
        tbl[6] = '{0,0,0,0,1, 0,0,0,0,0,1, 2};
        tbl[7] = '{0,0,0,0,1, 0,0,0,0,1,0, 1};
        tbl[8] = '{0,0,0,0,1, 0,0,0,0,0,0, 0};
        tbl[9] = '{0,0,0,0,0, 0,0,0,0,0,0, 0};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            s = idle();
            s.ir = tbl[i].ir; s.ia = 32'h1C00_0000 + 32'(i * 4);
            s.dr = tbl[i].dr; s.dw = tbl[i].dw; s.st = 4'hF;
            s.da = 32'h0000_0200; s.wd = 32'hA5A5_0000 + 32'(i);
            s.aok = tbl[i].aok; s.dok = tbl[i].dok; s.rd = 32'h5000_0000 + 32'(i);
            drive(s);
            #1;
            chk($sformatf("tbl%0d_mem_req", i), mem_req, tbl[i].e_mreq);
            chk($sformatf("tbl%0d_mem_wr", i), mem_wr, tbl[i].e_mwr);
            chk($sformatf("tbl%0d_inst_addr_ok", i), inst_sram_addr_ok, tbl[i].e_iaok);
            chk($sformatf("tbl%0d_data_addr_ok", i), data_sram_addr_ok, tbl[i].e_daok);
            chk($sformatf("tbl%0d_inst_data_ok", i), inst_sram_data_ok, tbl[i].e_idok);
            chk($sformatf("tbl%0d_data_data_ok", i), data_sram_data_ok, tbl[i].e_ddok);
            chk($sformatf("tbl%0d_ost_cnt", i), ost_cnt, tbl[i].e_cnt);
            @(posedge clk);
            @(negedge clk);
        end

        // Single inst read, data returned two cycles after acceptance.
        do_reset();
        s = idle(); s.ir = 1; s.ia = 32'h1C00_0000; s.aok = 1;
        cyc(s);
        chk("t1_inst_addr_ok", seen_iaok, 1);
        chk("t1_mem_addr", seen_maddr, 32'h1C00_0000);
        cyc(idle());
        s = idle(); s.dok = 1; s.rd = 32'hDEAD_BEEF;
        cyc(s);
        chk("t1_inst_data_ok", seen_idok, 1);
        chk("t1_data_data_ok", seen_ddok, 0);
        chk("t1_rdata", seen_irdata, 32'hDEAD_BEEF);

        // Contention: data write wins first, inst follows, responses routed in order.
        do_reset();
        s = idle(); s.ir = 1; s.ia = 32'h1C00_0010; s.dr = 1; s.dw = 1; s.st = 4'hF;
        s.da = 32'h100; s.wd = 32'h1234_5678; s.aok = 1;
        cyc(s);
        chk("t2_data_first", seen_daok, 1);
        chk("t2_mem_wr", seen_mwr, 1);
        s.dr = 0;
        cyc(s);
        chk("t2_inst_second", seen_iaok, 1);
        s = idle(); s.dok = 1; s.rd = 32'h0BAD_F00D;
        cyc(s);
        chk("t2_resp1_data", seen_ddok, 1);
        cyc(s);
        chk("t2_resp2_inst", seen_idok, 1);

        // Pending inst request holds the grant while data request arrives.
        do_reset();
        s = idle(); s.ir = 1; s.ia = 32'h1C00_0040;
        cyc(s);
        s.dr = 1; s.da = 32'h300; s.st = 4'h3; s.ds = 2'd1;
        cyc(s);
        chk("t3_locked_addr", seen_maddr, 32'h1C00_0040);
        chk("t3_no_data_ok", seen_daok, 0);
        cyc(s);
        chk("t3_locked_addr2", seen_maddr, 32'h1C00_0040);
        s.aok = 1;
        cyc(s);
        chk("t3_inst_accept", seen_iaok, 1);
        s.ir = 0;
        cyc(s);
        chk("t3_data_after", seen_daok, 1);

        // Fill to capacity; a pop does not bypass the full condition.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            s = idle(); s.ir = 1; s.ia = 32'h1C00_0100 + 32'(i * 4); s.aok = 1;
            cyc(s);
        end
        s = idle(); s.ir = 1; s.ia = 32'h1C00_0200; s.aok = 1;
        cyc(s);
        chk("t4_full_cnt", seen_cnt, 4);
        chk("t4_full_no_req", seen_mreq, 0);
        s.dok = 1; s.rd = 32'h7;
        cyc(s);
        chk("t4_no_bypass", seen_mreq, 0);
        chk("t4_pop_inst", seen_idok, 1);
        s.dok = 0;
        cyc(s);
        chk("t4_issue_cnt", seen_cnt, 3);
        chk("t4_issue", seen_iaok, 1);

        // Simultaneous push and pop keep the count.
        do_reset();
        s = idle(); s.ir = 1; s.ia = 32'h1C00_0300; s.aok = 1;
        cyc(s);
        s = idle(); s.dr = 1; s.da = 32'h400; s.aok = 1;
        cyc(s);
        s = idle(); s.ir = 1; s.ia = 32'h1C00_0304; s.aok = 1; s.dok = 1; s.rd = 32'h11;
        cyc(s);
        chk("t5_cnt_before", seen_cnt, 2);
        chk("t5_route_inst", seen_idok, 1);
        s = idle(); s.dok = 1; s.rd = 32'h22;
        cyc(s);
        chk("t5_cnt_kept", seen_cnt, 2);
        chk("t5_route_data", seen_ddok, 1);

        // Spurious data_ok with nothing outstanding.
        do_reset();
        s = idle(); s.dok = 1; s.rd = 32'h33;
        cyc(s);
        chk("t6_no_inst_ok", seen_idok, 0);
        chk("t6_no_data_ok", seen_ddok, 0);
        cyc(idle());
        chk("t6_cnt_zero", seen_cnt, 0);

        // Back-to-back contention: alternates with round-robin, data always wins otherwise.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.ir = 1; s.ia = 32'h1C00_0500; s.dr = 1; s.da = 32'h500; s.aok = 1;
            if (i == 2) begin
                s.dok = 1;
            end
            cyc(s);
            chk($sformatf("t7_grant%0d", i), seen_daok, RR_ON ? ((i % 2) == 0) : 1'b1);
        end

        do_reset();
        for (int i = 0; i < 600; i++) begin
            s.ir  = $urandom_range(0, 1);
            s.ia  = $urandom;
            s.dr  = $urandom_range(0, 1);
            s.dw  = $urandom_range(0, 1);
            s.ds  = 2'($urandom_range(0, 2));
            s.st  = 4'($urandom);
            s.da  = $urandom;
            s.wd  = $urandom;
            s.aok = ($urandom_range(0, 99) < 55);
            s.dok = ($urandom_range(0, 99) < 40);
            s.rd  = $urandom;
            cyc(s);
            if (i == 300) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
